// File: rtl/mma_pkg.sv
// rtl/mma_pkg.sv - shared constants and types for the matrix-multiply accelerator
package mma_pkg;

    localparam int OP_W  = 4;
    localparam int ACC_W = 10;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        CAPTURE,
        HOLD
    } seq_state_e;

endpackage

// File: rtl/operand_regfile.sv
// rtl/operand_regfile.sv - N-entry operand store with one write port and a combinational read
module operand_regfile #(
    parameter int N     = 4,
    parameter int OP_W  = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OP_W-1:0]  wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [OP_W-1:0]  rd_data
);

    logic [OP_W-1:0] mem_q [N];

    // Indices at or beyond N address nothing: writes drop, reads return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && (int'(wr_idx) < N)) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < N) begin
            rd_data = mem_q[rd_idx];
        end
    end

endmodule

// File: rtl/mac_operand_sequencer.sv
// rtl/mac_operand_sequencer.sv - streams an A row and B column into one MAC and returns the dot product
// Optional shadow result check enabled by SEQ_SHADOW_CHECK_EN (adds res_err).
module mac_operand_sequencer #(
    parameter int N     = 4,
    parameter int OP_W  = mma_pkg::OP_W,
    parameter int ACC_W = mma_pkg::ACC_W,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OP_W-1:0]  wr_data,
    input  logic             start,
    output logic             busy,
    output logic [OP_W-1:0]  mac_w,
    output logic [OP_W-1:0]  mac_x,
    output logic             mac_load,
    output logic             mac_clear,
    input  logic [ACC_W-1:0] mac_acc,
    output logic             res_valid,
    input  logic             res_ready,
`ifdef SEQ_SHADOW_CHECK_EN
    output logic             res_err,
`endif
    output logic [ACC_W-1:0] res_data
);
    import mma_pkg::*;

    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N - 1);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic             busy_q, busy_d;
    logic [OP_W-1:0]  mac_w_q, mac_w_d;
    logic [OP_W-1:0]  mac_x_q, mac_x_d;
    logic             mac_load_q, mac_load_d;
    logic             mac_clear_q, mac_clear_d;
    logic             res_valid_q, res_valid_d;
    logic [ACC_W-1:0] res_data_q, res_data_d;
    logic             idle_wr;
    logic [OP_W-1:0]  a_rd, b_rd;

    assign idle_wr = wr_en && (state_q == IDLE);

    // Read by next-state index so the registered operands line up with the FEED cycle.
    operand_regfile #(.N(N), .OP_W(OP_W), .IDX_W(IDX_W)) u_a_regs (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (idle_wr && (wr_sel == SEL_A)),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (k_d),
        .rd_data (a_rd)
    );

    operand_regfile #(.N(N), .OP_W(OP_W), .IDX_W(IDX_W)) u_b_regs (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (idle_wr && (wr_sel == SEL_B)),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (k_d),
        .rd_data (b_rd)
    );

    always_comb begin
        state_d = state_q;
        k_d     = '0;
        unique case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = FEED;
            FEED: begin
                if (k_q == K_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            CAPTURE: state_d = HOLD;
            HOLD:    if (res_valid_q && res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every output is a register decoded from the state being entered.
    always_comb begin
        busy_d      = (state_d != IDLE);
        mac_clear_d = (state_d == CLEAR);
        mac_load_d  = (state_d == FEED);
        mac_w_d     = mac_load_d ? a_rd : '0;
        mac_x_d     = mac_load_d ? b_rd : '0;
        res_valid_d = (state_d == HOLD);
        res_data_d  = (state_q == CAPTURE) ? mac_acc : res_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            busy_q      <= 1'b0;
            mac_w_q     <= '0;
            mac_x_q     <= '0;
            mac_load_q  <= 1'b0;
            mac_clear_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            mac_w_q     <= mac_w_d;
            mac_x_q     <= mac_x_d;
            mac_load_q  <= mac_load_d;
            mac_clear_q <= mac_clear_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign busy      = busy_q;
    assign mac_w     = mac_w_q;
    assign mac_x     = mac_x_q;
    assign mac_load  = mac_load_q;
    assign mac_clear = mac_clear_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

`ifdef SEQ_SHADOW_CHECK_EN
    localparam int SH_W = ACC_W + 1;

    logic [SH_W-1:0] shadow_q, shadow_d;
    logic            res_err_q, res_err_d;

    // Mirrors the MAC from the operands actually driven, so a swapped or dropped lane shows up.
    always_comb begin
        shadow_d  = shadow_q;
        res_err_d = res_err_q;
        if (state_q == CLEAR) begin
            shadow_d = '0;
        end else if (state_q == FEED) begin
            shadow_d = shadow_q + SH_W'(mac_w_q) * SH_W'(mac_x_q);
        end
        if (state_q == CAPTURE) begin
            res_err_d = (shadow_q != {1'b0, mac_acc});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= '0;
            res_err_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            res_err_q <= res_err_d;
        end
    end

    assign res_err = res_err_q;
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb/tb_mac_operand_sequencer.sv - scoreboard bench for mac_operand_sequencer with a behavioural MAC
module tb_mac_operand_sequencer;
    import mma_pkg::*;

    localparam int N     = 4;
    localparam int IDX_W = 2;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             wr_en     = 1'b0;
    logic             wr_sel    = 1'b0;
    logic [IDX_W-1:0] wr_idx    = '0;
    logic [OP_W-1:0]  wr_data   = '0;
    logic             start     = 1'b0;
    logic             res_ready = 1'b1;
    logic             busy, mac_load, mac_clear, res_valid;
    logic [OP_W-1:0]  mac_w, mac_x;
    logic [ACC_W-1:0] res_data;
    logic [ACC_W-1:0] acc_m = '0;
`ifdef SEQ_SHADOW_CHECK_EN
    logic             res_err;
`endif

    int errors = 0;
    int checks = 0;

    logic [OP_W-1:0]   a_m [N];
    logic [OP_W-1:0]   b_m [N];
    logic [2*OP_W-1:0] exp_ops [$];
    logic [ACC_W-1:0]  exp_res [$];
    logic              cleared = 1'b0;

    mac_operand_sequencer #(.N(N), .OP_W(OP_W), .ACC_W(ACC_W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .mac_w     (mac_w),
        .mac_x     (mac_x),
        .mac_load  (mac_load),
        .mac_clear (mac_clear),
        .mac_acc   (acc_m),
        .res_valid (res_valid),
        .res_ready (res_ready),
`ifdef SEQ_SHADOW_CHECK_EN
        .res_err   (res_err),
`endif
        .res_data  (res_data)
    );

    always #5 clk = ~clk;

    // Behavioural MAC; deliberately not reset so a fresh run must rely on CLEAR.
    always @(posedge clk) begin
        if (mac_clear) acc_m <= '0;
        else if (mac_load) acc_m <= acc_m + ACC_W'(mac_w) * ACC_W'(mac_x);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_ops.delete();
            exp_res.delete();
            cleared = 1'b0;
        end else begin
            if (mac_clear) begin
                check("clear_cycle_quiet", {mac_load, mac_w, mac_x}, 0);
                cleared = 1'b1;
            end
            if (mac_load) begin
                check("clear_before_load", cleared, 1);
                if (exp_ops.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load: got w=%0d x=%0d expected no load", mac_w, mac_x);
                end else begin
                    check("operand_pair", {mac_w, mac_x}, exp_ops.pop_front());
                end
            end else begin
                check("operands_zero_outside_feed", {mac_w, mac_x}, 0);
            end
            if (res_valid && res_ready) begin
                if (exp_res.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d expected none", res_data);
                end else begin
                    check("res_data", res_data, exp_res.pop_front());
                end
`ifdef SEQ_SHADOW_CHECK_EN
                check("res_err", res_err, 0);
`endif
                cleared = 1'b0;
            end
        end
    end

    task automatic wr(input logic sel, input int idx, input logic [OP_W-1:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_sel = sel; wr_idx = IDX_W'(idx); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (sel == SEL_A) a_m[idx] = d;
        else b_m[idx] = d;
    endtask

    // Vectors are written as hex nibbles, entry 0 first: 16'h1234 -> {1,2,3,4}.
    task automatic load_ops(input logic [15:0] av, input logic [15:0] bv);
        for (int k = 0; k < N; k++) begin
            wr(SEL_A, k, av[4*(N-1-k) +: 4]);
            wr(SEL_B, k, bv[4*(N-1-k) +: 4]);
        end
    endtask

    // mode: 0 normal, 1 poke start/wr_en during FEED, 2 reset in FEED k=2,
    //       3 write B[3]=4 together with start, 4 backpressure (res_ready low beforehand)
    task automatic run(input logic [ACC_W-1:0] exp, input int mode);
        int n;
        @(posedge clk); #1;
        start = 1'b1;
        if (mode == 3) begin
            wr_en = 1'b1; wr_sel = SEL_B; wr_idx = 2'd3; wr_data = 4'd4;
            b_m[3] = 4'd4;
        end
        for (int k = 0; k < N; k++) exp_ops.push_back({a_m[k], b_m[k]});
        if (mode != 2) exp_res.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
        check("busy_after_start", busy, 1);
        check("clear_after_start", mac_clear, 1);
        n = 0;
        while (!res_valid && n < 50) begin
            if (mode == 1 && n == 2) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = SEL_A; wr_idx = '0; wr_data = 4'd9;
            end
            if (mode == 2 && n == 3) begin
                check("feed_k2_operand", mac_w, a_m[2]);
                rst = 1'b1;
                #1;
                check("rst_outputs_zero",
                      {busy, mac_load, mac_clear, res_valid, mac_w, mac_x, res_data}, 0);
                @(posedge clk); @(posedge clk); #1;
                rst = 1'b0;
                for (int k = 0; k < N; k++) begin
                    a_m[k] = '0;
                    b_m[k] = '0;
                end
                check("idle_after_rst", busy, 0);
                return;
            end
            @(posedge clk); #1;
            n++;
            if (mode == 1 && n == 3) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
        end
        check("res_valid_latency", n, N + 2);
        check("busy_while_valid", busy, 1);
        if (mode == 4) begin
            repeat (5) begin
                @(posedge clk); #1;
                check("bp_valid_held", res_valid, 1);
                check("bp_data_held", res_data, exp);
                check("bp_busy_held", busy, 1);
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
        end
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_dropped", busy, 0);
        check("valid_dropped", res_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            a_m[k] = '0;
            b_m[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {busy, mac_load, mac_clear, res_valid, mac_w, mac_x, res_data}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", {busy, res_valid, mac_clear, mac_load}, 0);

        load_ops(16'h1234, 16'h5678);
        run(10'd70, 0);
        load_ops(16'hFFFF, 16'hFFFF);
        run(10'd900, 0);
        load_ops(16'h1111, 16'h1230);
        run(10'd10, 3);
        load_ops(16'h1234, 16'h5678);
        run(10'd70, 1);
        run(10'd70, 0);
        res_ready = 1'b0;
        run(10'd70, 4);
        run(10'd0, 2);
        run(10'd0, 0);
        load_ops(16'h1234, 16'h5678);
        run(10'd70, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_res.size() + exp_ops.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
